// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one internal write-port/read-port RAM (1-cycle registered read)
// between NUM_REQ requesters. One access per clock, round-robin arbitration with
// optional bounded burst locking for a single owner.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: IDLE winner is the lowest requesting
// index and the round-robin pointer is removed; LOCKED behaviour is unchanged.
module mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        cand;
`endif
  logic [IDX_W-1:0]        win;
  logic                    win_vld;
  logic [NUM_REQ-1:0]      gnt_c;

  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];
  logic                    acc_en;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [NUM_REQ-1:0]      rvalid_q;
  logic [DATA_WIDTH-1:0]   rd_q;

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Requester index following i, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (32'(i) == NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction
`endif

  // Split the flat request buses into per-requester fields.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitration: pick the winner and compute next FSM, owner, count and pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
    cand    = '0;
`endif
    win     = '0;
    win_vld = 1'b0;
    gnt_c   = '0;
    case (state_q)
      ST_IDLE: begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          if (!win_vld && req[IDX_W'(k)]) begin
            win_vld = 1'b1;
            win     = IDX_W'(k);
          end
`else
          cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
          if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
          end
`endif
        end
        if (win_vld) begin
          if (lock[win] && (MAX_BURST > 1)) begin
            state_d = ST_LOCKED;
            owner_d = win;
            cnt_d   = CNT_W'(1);
          end else begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_d = next_idx(win);
`endif
          end
        end
      end
      ST_LOCKED: begin
        if (req[owner_q]) begin
          win_vld = 1'b1;
          win     = owner_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        // Lock release or burst limit ends ownership; a same-cycle grant is the last access.
        if (!lock[owner_q] ||
            (req[owner_q] && (cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          ptr_d   = next_idx(owner_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (win_vld) gnt_c[win] = 1'b1;
  end

  // Grant and RAM access are suppressed while reset is asserted.
  assign gnt       = reset_n ? gnt_c : '0;
  assign acc_en    = win_vld & reset_n;
  assign acc_we    = we[win];
  assign acc_addr  = addr_a[win];
  assign acc_wdata = wdata_a[win];

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // RAM write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we) mem[acc_addr] <= acc_wdata;
  end

  // Registered read port and per-requester read-valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      rd_q     <= '0;
    end else begin
      rvalid_q <= '0;
      if (acc_en && !acc_we) begin
        rvalid_q[win] <= 1'b1;
        rd_q          <= mem[acc_addr];
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? rd_q : '0;
  assign busy   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req, lock, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_locked;
  int          m_owner, m_cnt, m_ptr;
  logic [N-1:0] m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [int];

  function automatic int m_winner();
    int j;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (m_ptr + k) % N;
`endif
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    w = m_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic m_reset();
    m_locked = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rv = '0; m_rd = '0;
  endtask

  // Advance one clock and apply the access/arbitration rules to the model.
  task automatic tick();
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic wr;
    logic [N-1:0] lk;
    a = '0; d = '0; wr = 1'b0;
    w  = m_winner();
    lk = lock;
    if (w >= 0) begin
      a  = addr[w*AW +: AW];
      d  = wdata[w*DW +: DW];
      wr = we[w];
    end
    @(posedge clk);
    m_rv = '0;
    m_rd = '0;
    if (w >= 0) begin
      if (wr) m_mem[int'(a)] = d;
      else begin
        m_rv[w] = 1'b1;
        m_rd    = m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
      end
    end
    if (!m_locked) begin
      if (w >= 0) begin
        if (lk[w] && MB > 1) begin
          m_locked = 1'b1; m_owner = w; m_cnt = 1;
        end else m_ptr = (w + 1) % N;
      end
    end else begin
      if (w >= 0) m_cnt++;
      if (!lk[m_owner] || m_cnt == MB) begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit r, input bit l, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; lock[i] = l; we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_bus(input int n);
    req = '0; lock = '0; we = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '1; lock = '0; we = '0; addr = '0; wdata = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({gnt, rvalid, busy, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset gnt=%b rvalid=%b busy=%b rdata=%h required all zero", gnt, rvalid, busy, rdata);
    end
    @(negedge clk);
    req = '0;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, rvalid, busy, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_release gnt=%b rvalid=%b busy=%b rdata=%h required all zero", gnt, rvalid, busy, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    // Populate addresses 0..15 with random data through requester 0.
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b1, 1'b0, 1'b1, AW'(k), $urandom);
      #1;
      n_cmp++;
      if ({gnt, rvalid, busy, rdata} !== {m_gnt(), m_rv, m_locked, m_rd}) begin
        n_fail++;
        $display("FAIL init_write k=%0d gnt=%b/%b rvalid=%b/%b busy=%b/%b rdata=%h/%h", k,
                 gnt, m_gnt(), rvalid, m_rv, busy, m_locked, rdata, m_rd);
      end
      tick();
    end
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_read_gnt gnt=%b required 0001", gnt);
    end
    tick();
    req = '0;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_read_data rvalid=%b rdata=%h required 0001 deadbeef", rvalid, rdata);
    end
    tick();
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0000, 32'h0}) begin
      n_fail++;
      $display("FAIL single_read_after rvalid=%b rdata=%h required 0000 00000000", rvalid, rdata);
    end
    idle_bus(1);
  endtask

  task automatic test_round_robin();
    int start;
    logic [N-1:0] eg, erv;
`ifdef MEM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'($urandom_range(0, 15)), '0);
    for (int c = 0; c < 9; c++) begin
      eg = '0; erv = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      eg[0] = 1'b1;
      if (c > 0) erv[0] = 1'b1;
`else
      eg[(start + c) % N] = 1'b1;
      if (c > 0) erv[(start + c - 1) % N] = 1'b1;
`endif
      #1;
      n_cmp++;
      if ({gnt, rvalid} !== {eg, erv}) begin
        n_fail++;
        $display("FAIL rr_order c=%0d gnt=%b/%b rvalid=%b/%b", c, gnt, eg, rvalid, erv);
      end
      n_cmp++;
      if ({gnt, rvalid, busy, rdata} !== {m_gnt(), m_rv, m_locked, m_rd}) begin
        n_fail++;
        $display("FAIL rr_model c=%0d gnt=%b/%b rvalid=%b/%b busy=%b/%b rdata=%h/%h", c,
                 gnt, m_gnt(), rvalid, m_rv, busy, m_locked, rdata, m_rd);
      end
      tick();
    end
    idle_bus(2);
  endtask

  task automatic test_burst_lock();
    set_req(2, 1'b1, 1'b1, 1'b0, 8'h10, '0);
    for (int c = 0; c < 12; c++) begin
      if (c == 1) set_req(1, 1'b1, 1'b0, 1'b0, 8'h05, '0);
      #1;
      if (c < 8) begin
        n_cmp++;
        if (gnt !== 4'b0100 || busy !== (c != 0)) begin
          n_fail++;
          $display("FAIL burst_owner c=%0d gnt=%b busy=%b required 0100 %0d", c, gnt, busy, c != 0);
        end
      end else if (c == 8) begin
        n_cmp++;
        if (gnt !== 4'b0010 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_exit gnt=%b busy=%b required 0010 0", gnt, busy);
        end
      end
      n_cmp++;
      if ({gnt, rvalid, busy, rdata} !== {m_gnt(), m_rv, m_locked, m_rd}) begin
        n_fail++;
        $display("FAIL burst_model c=%0d gnt=%b/%b rvalid=%b/%b busy=%b/%b rdata=%h/%h", c,
                 gnt, m_gnt(), rvalid, m_rv, busy, m_locked, rdata, m_rd);
      end
      if (c == 8) req[1] = 1'b0;
      tick();
    end
    idle_bus(2);
  endtask

  task automatic test_lock_bubble();
    int owner_grants;
    owner_grants = 0;
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h03, '0);
    for (int c = 0; c < 11; c++) begin
      if (c == 1) set_req(3, 1'b1, 1'b0, 1'b0, 8'h07, '0);
      req[0] = !(c == 3 || c == 4) && c < 10;
      #1;
      if (c == 3 || c == 4) begin
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble c=%0d gnt=%b busy=%b required 0000 1", c, gnt, busy);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if (gnt !== 4'b1000 || busy !== 1'b0 || owner_grants !== MB) begin
          n_fail++;
          $display("FAIL bubble_exit gnt=%b busy=%b owner_grants=%0d required 1000 0 %0d",
                   gnt, busy, owner_grants, MB);
        end
      end
      if (gnt[0]) owner_grants++;
      n_cmp++;
      if ({gnt, rvalid, busy, rdata} !== {m_gnt(), m_rv, m_locked, m_rd}) begin
        n_fail++;
        $display("FAIL bubble_model c=%0d gnt=%b/%b rvalid=%b/%b busy=%b/%b rdata=%h/%h", c,
                 gnt, m_gnt(), rvalid, m_rv, busy, m_locked, rdata, m_rd);
      end
      tick();
    end
    idle_bus(2);
  endtask

  task automatic test_back_to_back();
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h22, 32'h5A5A5A5A);
    tick();
    req[1] = 1'b0;
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h22, '0);
    #1;
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_gnt gnt=%b required 1000", gnt);
    end
    tick();
    req = '0;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b1000, 32'h5A5A5A5A}) begin
      n_fail++;
      $display("FAIL b2b_data rvalid=%b rdata=%h required 1000 5a5a5a5a", rvalid, rdata);
    end
    idle_bus(1);
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h40, 32'h12345678);
    tick();
    req = '0;
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h01, '0);
    tick();
    req = '0;
    set_req(2, 1'b1, 1'b1, 1'b0, 8'h02, '0);
    tick();
    #1;
    n_cmp++;
    if ({gnt, rvalid, busy} !== {4'b0100, 4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset gnt=%b rvalid=%b busy=%b required 0100 0100 1", gnt, rvalid, busy);
    end
    set_req(0, 1'b1, 1'b0, 1'b1, 8'h40, 32'hFFFFFFFF);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, rvalid, busy, rdata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset gnt=%b rvalid=%b busy=%b rdata=%h required all zero", gnt, rvalid, busy, rdata);
    end
    repeat (2) @(negedge clk);
    m_reset();
    reset_n = 1'b1;
    req = '0; lock = '0;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h40, '0);
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h03, '0);
    #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_gnt gnt=%b required 0001", gnt);
    end
    tick();
    req[0] = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, rdata} !== {4'b0001, 32'h12345678}) begin
      n_fail++;
      $display("FAIL reset_no_write rvalid=%b rdata=%h required 0001 12345678", rvalid, rdata);
    end
    idle_bus(2);
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'b1, lock[i], 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        lock[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      n_cmp++;
      if ({gnt, rvalid, busy, rdata} !== {m_gnt(), m_rv, m_locked, m_rd}) begin
        n_fail++;
        $display("FAIL random c=%0d gnt=%b/%b rvalid=%b/%b busy=%b/%b rdata=%h/%h", c,
                 gnt, m_gnt(), rvalid, m_rv, busy, m_locked, rdata, m_rd);
      end
      n_cmp++;
      if (!$onehot0(gnt) || !$onehot0(rvalid)) begin
        n_fail++;
        $display("FAIL onehot c=%0d gnt=%b rvalid=%b required one-hot-or-zero", c, gnt, rvalid);
      end
      w = m_winner();
      tick();
      if (w >= 0) req[w] = 1'b0;
    end
    idle_bus(2);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_lock_bubble();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
